// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer for the RV32I pipeline: drives a req/ack data bus,
// freezes the pipeline while an access is outstanding, and builds strobes, lane data and extended load data.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  ErrClr,
    output logic                  StallM,
    output logic                  KillW,
    output logic [DATA_WIDTH-1:0] DMRd,
    output logic                  MemErr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_n_s;
    logic [CW-1:0] cnt_r;
    logic [2:0]    f3_r;
    logic [1:0]    alo_r;
    logic          kill_r;
    logic          access_s;
    logic          illegal_s;
    logic          start_s;
    logic          fault_s;
    logic          ack_s;
    logic          tmo_s;

    function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   lane_strb = 4'b0001 << a;
            2'b01:   lane_strb = 4'b0011 << {a[1], 1'b0};
            2'b10:   lane_strb = 4'b1111;
            default: lane_strb = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'h000000, b};
            3'b101:  load_extend = {16'h0000, h};
            default: load_extend = w;
        endcase
    endfunction

    assign access_s = MemReadM | MemWriteM;

    // Classify the M-stage access as illegal: conflicting strobes, bad size code or misalignment.
    always_comb begin
        illegal_s = 1'b0;
        if (MemReadM && MemWriteM) begin
            illegal_s = 1'b1;
        end else if (MemWriteM && Funct3M[2]) begin
            illegal_s = 1'b1;
        end else begin
            case (Funct3M)
                3'b000, 3'b100: illegal_s = 1'b0;
                3'b001, 3'b101: illegal_s = ALUResultM[0];
                3'b010:         illegal_s = (ALUResultM[1:0] != 2'b00);
                default:        illegal_s = 1'b1;
            endcase
        end
    end

    // Next-state, stall and per-cycle event strobes.
    always_comb begin
        state_n_s = state_r;
        StallM    = 1'b0;
        start_s   = 1'b0;
        fault_s   = 1'b0;
        ack_s     = 1'b0;
        tmo_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    StallM = 1'b1;
                    if (illegal_s) begin
                        fault_s   = 1'b1;
                        state_n_s = DONE;
                    end else begin
                        start_s   = 1'b1;
                        state_n_s = REQ;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            REQ: begin
                StallM = 1'b1;
                // An ack in the last allowed cycle still completes the access normally.
                if (mem_ack) begin
                    ack_s     = 1'b1;
                    state_n_s = DONE;
                end else if (cnt_r == CNT_LAST) begin
                    tmo_s     = 1'b1;
                    state_n_s = DONE;
                end else begin
                    state_n_s = REQ;
                end
            end
            DONE: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    assign KillW = (state_r == DONE) & kill_r;

    // State register and ack-wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n_s;
            if (start_s) begin
                cnt_r <= '0;
            end else if (state_r == REQ && !ack_s && !tmo_s) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Bus-side registers, loaded at access start and held stable until the access ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            f3_r      <= 3'b000;
            alo_r     <= 2'b00;
        end else if (start_s) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            mem_wdata <= MemWriteM ? lane_wdata(Funct3M, WriteDataM) : 32'h0000_0000;
            mem_wstrb <= MemWriteM ? lane_strb(Funct3M, ALUResultM[1:0]) : 4'b0000;
            f3_r      <= Funct3M;
            alo_r     <= ALUResultM[1:0];
        end else if (ack_s || tmo_s) begin
            mem_req   <= 1'b0;
        end else begin
            mem_req   <= mem_req;
        end
    end

    // Load data for the W stage; a timed-out access returns zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DMRd <= '0;
        end else if (ack_s && !mem_we) begin
            DMRd <= load_extend(f3_r, alo_r, mem_rdata);
        end else if (tmo_s) begin
            DMRd <= '0;
        end else begin
            DMRd <= DMRd;
        end
    end

    // Kill flag for the faulting writeback and the sticky error flag (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_r <= 1'b0;
            MemErr <= 1'b0;
        end else begin
            if (fault_s || tmo_s) begin
                kill_r <= 1'b1;
            end else if (state_r == DONE) begin
                kill_r <= 1'b0;
            end else begin
                kill_r <= kill_r;
            end
            if (fault_s || tmo_s) begin
                MemErr <= 1'b1;
            end else if (ErrClr) begin
                MemErr <= 1'b0;
            end else begin
                MemErr <= MemErr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: each access pushes its expected completion,
// which a negedge monitor pops and compares when the DONE cycle appears.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [2:0]  Funct3M = 3'b000;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic        ErrClr = 1'b0;
    logic        StallM, KillW, MemErr, mem_req, mem_we;
    logic [31:0] DMRd, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [31:0] dmrd;
        bit          chk_d;
        logic        kill;
        logic        err;
        int          stalls;
        int          reqs;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];

    mem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ErrClr(ErrClr), .StallM(StallM), .KillW(KillW), .DMRd(DMRd), .MemErr(MemErr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] dmrd, input bit chk_d, input logic kill,
                                input logic err, input int stalls, input int reqs,
                                input logic [31:0] addr, input logic [3:0] strb,
                                input logic we, input logic [31:0] wdata);
        exp_t e;
        e.dmrd = dmrd; e.chk_d = chk_d; e.kill = kill; e.err = err;
        e.stalls = stalls; e.reqs = reqs; e.addr = addr; e.strb = strb;
        e.we = we; e.wdata = wdata;
        return e;
    endfunction

    // Monitor: count stall and request cycles, capture bus values, check at DONE.
    int          stall_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;
    logic        cap_we;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt = 0;
            req_cnt   = 0;
        end else begin
            if (mem_req) begin
                req_cnt++;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_strb  = mem_wstrb;
                cap_we    = mem_we;
            end
            if (StallM) begin
                stall_cnt++;
            end else if (stall_cnt > 0) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("stalls", 32'(stall_cnt), 32'(e.stalls));
                    chk("reqs", 32'(req_cnt), 32'(e.reqs));
                    chk("killw", {31'd0, KillW}, {31'd0, e.kill});
                    chk("memerr", {31'd0, MemErr}, {31'd0, e.err});
                    if (e.chk_d) chk("dmrd", DMRd, e.dmrd);
                    if (e.reqs > 0) begin
                        chk("addr", cap_addr, e.addr);
                        chk("we", {31'd0, cap_we}, {31'd0, e.we});
                        chk("wstrb", {28'd0, cap_strb}, {28'd0, e.strb});
                        if (e.we) chk("wdata", cap_wdata, e.wdata);
                    end
                end
                stall_cnt = 0;
                req_cnt   = 0;
            end
        end
    end

    // Drive one access from an IDLE cycle, answer it as memory, release after DONE.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_wait, input logic [31:0] rdata, input exp_t e);
        int waits = 0;
        int guard = 0;
        exp_q.push_back(e);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        @(posedge clk); #1;
        while (StallM && guard < 60) begin
            if (mem_req && waits == ack_wait) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_ack = 1'b0;
            end
            waits++;
            guard++;
            @(posedge clk); #1;
        end
        if (guard >= 60) chk("op_guard", {31'd0, StallM}, 32'd0);
        mem_ack = 1'b0;
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    task automatic clear_err();
        chk("err_before_clr", {31'd0, MemErr}, 32'd1);
        ErrClr = 1'b1;
        @(posedge clk); #1;
        ErrClr = 1'b0;
        chk("err_after_clr", {31'd0, MemErr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_killw", {31'd0, KillW}, 32'd0);
        chk("rst_dmrd", DMRd, 32'd0);
        chk("rst_memerr", {31'd0, MemErr}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Loads
        run_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF,
               mk(32'hDEADBEEF, 1, 0, 0, 2, 1, 32'h100, 4'b0000, 0, 32'h0));
        run_op(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233,
               mk(32'hFFFFFF80, 1, 0, 0, 2, 1, 32'h100, 4'b0000, 0, 32'h0));
        run_op(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233,
               mk(32'h00000080, 1, 0, 0, 2, 1, 32'h100, 4'b0000, 0, 32'h0));
        run_op(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80112233,
               mk(32'hFFFF8011, 1, 0, 0, 3, 2, 32'h100, 4'b0000, 0, 32'h0));
        run_op(1, 0, 3'b101, 32'h102, 32'h0, 0, 32'h80112233,
               mk(32'h00008011, 1, 0, 0, 2, 1, 32'h100, 4'b0000, 0, 32'h0));
        run_op(1, 0, 3'b000, 32'h101, 32'h0, 0, 32'h80112233,
               mk(32'h00000022, 1, 0, 0, 2, 1, 32'h100, 4'b0000, 0, 32'h0));

        // Stores
        run_op(0, 1, 3'b000, 32'h201, 32'h000000AB, 3, 32'h0,
               mk(32'h0, 0, 0, 0, 5, 4, 32'h200, 4'b0010, 1, 32'hABABABAB));
        run_op(0, 1, 3'b001, 32'h202, 32'h1234CAFE, 0, 32'h0,
               mk(32'h0, 0, 0, 0, 2, 1, 32'h200, 4'b1100, 1, 32'hCAFECAFE));
        run_op(0, 1, 3'b010, 32'h204, 32'h12345678, 2, 32'h0,
               mk(32'h0, 0, 0, 0, 4, 3, 32'h204, 4'b1111, 1, 32'h12345678));
        chk("dmrd_hold", DMRd, 32'h00000022);

        // Faults: no bus request, kill and sticky error
        run_op(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0,
               mk(32'h0, 0, 1, 1, 1, 0, 32'h0, 4'b0, 0, 32'h0));
        clear_err();
        run_op(0, 1, 3'b100, 32'h200, 32'h0, 0, 32'h0,
               mk(32'h0, 0, 1, 1, 1, 0, 32'h0, 4'b0, 0, 32'h0));
        clear_err();
        run_op(1, 1, 3'b010, 32'h200, 32'h0, 0, 32'h0,
               mk(32'h0, 0, 1, 1, 1, 0, 32'h0, 4'b0, 0, 32'h0));
        clear_err();
        run_op(1, 0, 3'b011, 32'h200, 32'h0, 0, 32'h0,
               mk(32'h0, 0, 1, 1, 1, 0, 32'h0, 4'b0, 0, 32'h0));
        clear_err();
        ErrClr = 1'b1;
        run_op(1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0,
               mk(32'h0, 0, 1, 1, 1, 0, 32'h0, 4'b0, 0, 32'h0));
        ErrClr = 1'b0;
        chk("err_cleared_after_win", {31'd0, MemErr}, 32'd0);

        // Timeout, then ack in the final allowed cycle
        run_op(1, 0, 3'b010, 32'h300, 32'h0, -1, 32'h0,
               mk(32'h0, 1, 1, 1, 16, 15, 32'h300, 4'b0000, 0, 32'h0));
        clear_err();
        run_op(1, 0, 3'b010, 32'h304, 32'h0, 14, 32'hCAFEF00D,
               mk(32'hCAFEF00D, 1, 0, 0, 16, 15, 32'h304, 4'b0000, 0, 32'h0));

        // Reset during REQ, stray ack afterwards, then a normal load
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("req_before_rst", {31'd0, mem_req}, 32'd1);
        MemReadM = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, StallM}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
        chk("stray_ack_stall", {31'd0, StallM}, 32'd0);
        chk("stray_ack_dmrd", DMRd, 32'd0);
        chk("stray_ack_kill", {31'd0, KillW}, 32'd0);
        run_op(1, 0, 3'b010, 32'h404, 32'h0, 0, 32'h0BADF00D,
               mk(32'h0BADF00D, 1, 0, 0, 2, 1, 32'h404, 4'b0000, 0, 32'h0));

        @(posedge clk); #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access sequencer for the pipelined RV32I core. It sits between the M stage and a variable-latency data memory with a req/ack handshake, and it freezes the pipeline while an access is outstanding. It also generates byte strobes and sign/zero-extended load data (DMRd) for the M→W pipeline register, detects misaligned or illegal accesses and bus timeouts, and kills the faulting writeback.

## Interface
- DATA_WIDTH, 32, data and address width (fixed at 32 for RV32I)
- TIMEOUT, 15, max REQ cycles without mem_ack before abort (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- MemReadM  in  1  M-stage instruction is a load
- MemWriteM  in  1  M-stage instruction is a store
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data (rs2)
- ErrClr  in  1  clears MemErr
- StallM  out  1  hold PC and F/D/E/M pipeline registers
- KillW  out  1  forces RegWriteW=0 for the instruction leaving M
- DMRd  out  32  extended load data, valid in DONE
- MemErr  out  1  sticky fault flag
- mem_req, mem_we  out  1 each  request / write-enable
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes (0 for reads)
- mem_ack  in  1  access complete; mem_rdata valid on reads
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, no access (MemReadM=MemWriteM=0): StallM=0 and stay in IDLE.
- IDLE, valid access: StallM=1. Latch addr, we, wstrb, wdata and Funct3M, clear the counter, then go to REQ.
- IDLE, fault: StallM=1, set MemErr, set the kill flag, go to DONE. No bus request. Faults are:
  - both MemReadM and MemWriteM high;
  - Funct3M not in {000,001,010,100,101}, or a store with Funct3M[2]=1;
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠00.
- REQ: mem_req=1 and StallM=1. All mem_* outputs are registered and held stable.
  - mem_ack=1: capture the extended mem_rdata into DMRd (reads), go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack, deassert mem_req, set MemErr and kill, and load DMRd with 0 before going to DONE.
  - If ack arrives in the final timeout cycle, the ack wins.
- DONE: StallM=0, so the pipeline advances at this edge. KillW = kill flag. The kill flag clears and the FSM returns to IDLE.
- Store lanes:
  - B: wstrb=0001<<addr[1:0], wdata={4{byte}}.
  - H: wstrb=0011<<{addr[1],1'b0}, wdata={2{half}}.
  - W: wstrb=1111.
- Load extraction:
  - Byte lane addr[1:0], half lane addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- mem_ack outside REQ is ignored.
- MemErr is sticky. It clears on ErrClr, unless a new fault sets it in the same cycle, in which case set wins.
- A timed-out store sets KillW as well; this is harmless.

## Timing
- Reset values (async, immediate): state IDLE, StallM 0, KillW 0, DMRd 0, MemErr 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, counter 0.
- Reset asserted mid-REQ drops mem_req in the same instant. An ack arriving after reset is ignored.
- StallM is combinational from state and the M inputs: high in the IDLE detect cycle and throughout REQ, low in DONE.
- Minimum access (ack in first REQ cycle) takes 3 cycles: IDLE(stall) → REQ(stall) → DONE. Each extra ack wait adds 1 cycle.
- Timeout access: 1 + TIMEOUT stall cycles, then DONE.
- Fault: IDLE(stall) → DONE, 2 cycles, with no mem_req pulse.
- DMRd and KillW are valid only in DONE. DMRd holds its last value elsewhere.
- Back-to-back accesses: the next instruction is evaluated in the IDLE cycle after DONE.

## Test plan
- LW at 0x100, mem_rdata=0xDEADBEEF, ack in first REQ cycle → mem_addr=0x100, wstrb=0000, StallM high for 2 cycles, DMRd=0xDEADBEEF in DONE, KillW=0.
- LB at 0x103 and LBU at 0x103, rdata=0x80112233 → DMRd=0xFFFFFF80 and 0x00000080; LH at 0x102 → 0xFFFF8011.
- SB at 0x201, WriteDataM=0x000000AB, ack after 3 waits → mem_we=1, wstrb=0010, wdata=0xABABABAB, StallM high for 5 cycles.
- LW at 0x102 → no mem_req, MemErr=1, KillW=1 in DONE. ErrClr clears MemErr the following cycle.
- LW with no ack, TIMEOUT=15 → mem_req high for exactly 15 cycles, then MemErr=1, DMRd=0, KillW=1. A second run with ack in the 15th cycle → normal completion, MemErr stays 0.
- rst_n pulled low during REQ → mem_req, StallM and the state return immediately to reset values. A later ack is ignored and the next LW completes normally.
